// File: rtl/uart_bus_responder_if.sv
// ----------------------------------------------------------------------------
// uart_bus_responder_if
//
// Purpose: the parallel-bus handshake between a bus master and the UART
// responder: the two active-low strobes from the master and the three status
// flags returned by the responder.
//
// Signals:
//   uart_rdn        master -> responder  active-low read strobe
//   uart_wrn        master -> responder  active-low write strobe
//   uart_dataready  responder -> master  high = received byte waiting
//   uart_tbre       responder -> master  high = transmit holding register empty
//   uart_tsre       responder -> master  high = transmitter completely idle
//
// The 8-bit data bus is not carried here. It is a tristate pin shared by both
// sides, so it stays a plain inout port on the responder and the drivers
// resolve on the net itself.
// ----------------------------------------------------------------------------
interface uart_bus_responder_if;
   logic uart_rdn;
   logic uart_wrn;
   logic uart_dataready;
   logic uart_tbre;
   logic uart_tsre;

   modport master (
      output uart_rdn,
      output uart_wrn,
      input  uart_dataready,
      input  uart_tbre,
      input  uart_tsre
   );

   modport slave (
      input  uart_rdn,
      input  uart_wrn,
      output uart_dataready,
      output uart_tbre,
      output uart_tsre
   );
endinterface

// File: rtl/uart_bus_responder.sv
// ----------------------------------------------------------------------------
// uart_bus_responder
//
// Purpose: a byte-wide bus-attached UART. A write strobe loads one byte into a
// single transmit holding register that feeds a serial shifter; a receiver
// samples rxd and holds the most recent good byte for the bus to read back.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (4..65535), default 434
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_bus_responder_if.slave (strobes in, status flags out)
//   data   8-bit bidirectional bus, driven only while uart_rdn is low
//   txd    serial transmit line, idles high
//   rxd    serial receive line, asynchronous to clk
//
// Configuration:
//   UART_PARITY_EN  when defined, frames carry an even-parity bit between the
//                   data and stop bits (8E1); the transmitter inserts it and
//                   the receiver drops frames whose parity is wrong.
//                   Undefined (default) gives plain 8N1 frames.
// ----------------------------------------------------------------------------
module uart_bus_responder #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_bus_responder_if.slave bus,
   inout  wire  [7:0]         data,
   output logic               txd,
   input  logic               rxd
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef UART_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP
   } rx_state_e;

   // Strobe history for edge detection
   logic wrn_q, rdn_q;
   logic wrn_fall, rdn_rise;

   // Transmit path
   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [7:0]  tx_hold_q, tx_hold_d;
   logic        tbre_q, tbre_d;
   logic        tsre_q, tsre_d;
   logic        txd_q, txd_d;
   logic        tx_bit_end, tx_load;
`ifdef UART_PARITY_EN
   logic        tx_par_q, tx_par_d;
`endif

   // Receive path
   logic        rx_meta_q, rx_sync_q, rx_sync_prev_q;
   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  rx_hold_q, rx_hold_d;
   logic        dataready_q, dataready_d;
   logic        rx_bit_end, frame_ok;
`ifdef UART_PARITY_EN
   logic        rx_par_err_q, rx_par_err_d;
`endif

   assign wrn_fall = wrn_q & ~bus.uart_wrn;
   assign rdn_rise = ~rdn_q & bus.uart_rdn;

   assign bus.uart_dataready = dataready_q;
   assign bus.uart_tbre      = tbre_q;
   assign bus.uart_tsre      = tsre_q;
   assign txd                = txd_q;

   // Reads are purely combinational: the bus sees the holding register for as
   // long as the read strobe is low, and nothing changes until it rises.
   assign data = bus.uart_rdn ? 8'hzz : rx_hold_q;

   // Transmitter: next-state for the bit-timing FSM, the holding register and
   // the status flags. A load happens either from IDLE or straight out of a
   // finishing STOP bit so that queued bytes go out back-to-back.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_hold_d  = tx_hold_q;
      tbre_d     = tbre_q;
      tsre_d     = tsre_q;
      tx_load    = 1'b0;
`ifdef UART_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      tx_bit_end = (tx_cnt_q == BIT_LAST);

      if (tx_state_q != TX_IDLE) begin
         tx_cnt_d = tx_bit_end ? 16'd0 : tx_cnt_q + 16'd1;
      end

      case (tx_state_q)
         TX_IDLE: begin
            if (!tbre_q) begin
               tx_load = 1'b1;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_state_d = TX_DATA;
               tx_bit_d   = 3'd0;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  tx_state_d = TX_PARITY;
`else
                  tx_state_d = TX_STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         TX_PARITY: begin
            if (tx_bit_end) begin
               tx_state_d = TX_STOP;
            end
         end
`endif
         TX_STOP: begin
            if (tx_bit_end) begin
               if (!tbre_q) begin
                  tx_load = 1'b1;
               end else begin
                  tx_state_d = TX_IDLE;
                  tsre_d     = 1'b1;
               end
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
         end
      endcase

      if (tx_load) begin
         tx_shift_d = tx_hold_q;
         tbre_d     = 1'b1;
         tsre_d     = 1'b0;
         tx_state_d = TX_START;
         tx_cnt_d   = 16'd0;
`ifdef UART_PARITY_EN
         tx_par_d   = ^tx_hold_q;
`endif
      end

      // A write only lands while the holding register is empty; a load and an
      // accepted write can never coincide because they need opposite tbre.
      if (wrn_fall && tbre_q) begin
         tx_hold_d = data;
         tbre_d    = 1'b0;
         tsre_d    = 1'b0;
      end

      // txd is registered from the next state so it changes on the same edge
      // as the FSM and never glitches.
      case (tx_state_d)
         TX_START:  txd_d = 1'b0;
         TX_DATA:   txd_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
         TX_PARITY: txd_d = tx_par_d;
`endif
         default:   txd_d = 1'b1;
      endcase
   end

   // Receiver: start-bit qualification at half a bit, then one sample per bit
   // period. Only a clean stop bit (and good parity when enabled) commits the
   // byte; a read-strobe rising edge clears dataready unless a frame lands in
   // the same cycle.
   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_hold_d   = rx_hold_q;
      dataready_d = dataready_q;
      frame_ok    = 1'b0;
`ifdef UART_PARITY_EN
      rx_par_err_d = rx_par_err_q;
`endif
      rx_bit_end  = (rx_cnt_q == BIT_LAST);

      if (rx_state_q != RX_IDLE) begin
         rx_cnt_d = rx_bit_end ? 16'd0 : rx_cnt_q + 16'd1;
      end

      case (rx_state_q)
         RX_IDLE: begin
            if (rx_sync_prev_q && !rx_sync_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = 16'd0;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = 16'd0;
               if (rx_sync_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_bit_d   = 3'd0;
               end
            end
         end
         RX_DATA: begin
            if (rx_bit_end) begin
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  rx_state_d = RX_PARITY;
`else
                  rx_state_d = RX_STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         RX_PARITY: begin
            if (rx_bit_end) begin
               rx_par_err_d = rx_sync_q ^ (^rx_shift_q);
               rx_state_d   = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (rx_bit_end) begin
               rx_state_d = RX_IDLE;
`ifdef UART_PARITY_EN
               frame_ok = rx_sync_q & ~rx_par_err_q;
`else
               frame_ok = rx_sync_q;
`endif
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase

      if (frame_ok) begin
         rx_hold_d   = rx_shift_q;
         dataready_d = 1'b1;
      end else if (rdn_rise) begin
         dataready_d = 1'b0;
      end
   end

   // State registers. The rxd synchronizer and the strobe history reset to the
   // idle-high level so releasing reset never looks like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrn_q          <= 1'b1;
         rdn_q          <= 1'b1;
         tx_state_q     <= TX_IDLE;
         tx_cnt_q       <= 16'd0;
         tx_bit_q       <= 3'd0;
         tx_shift_q     <= 8'd0;
         tx_hold_q      <= 8'd0;
         tbre_q         <= 1'b1;
         tsre_q         <= 1'b1;
         txd_q          <= 1'b1;
         rx_meta_q      <= 1'b1;
         rx_sync_q      <= 1'b1;
         rx_sync_prev_q <= 1'b1;
         rx_state_q     <= RX_IDLE;
         rx_cnt_q       <= 16'd0;
         rx_bit_q       <= 3'd0;
         rx_shift_q     <= 8'd0;
         rx_hold_q      <= 8'd0;
         dataready_q    <= 1'b0;
`ifdef UART_PARITY_EN
         tx_par_q       <= 1'b0;
         rx_par_err_q   <= 1'b0;
`endif
      end else begin
         wrn_q          <= bus.uart_wrn;
         rdn_q          <= bus.uart_rdn;
         tx_state_q     <= tx_state_d;
         tx_cnt_q       <= tx_cnt_d;
         tx_bit_q       <= tx_bit_d;
         tx_shift_q     <= tx_shift_d;
         tx_hold_q      <= tx_hold_d;
         tbre_q         <= tbre_d;
         tsre_q         <= tsre_d;
         txd_q          <= txd_d;
         rx_meta_q      <= rxd;
         rx_sync_q      <= rx_meta_q;
         rx_sync_prev_q <= rx_sync_q;
         rx_state_q     <= rx_state_d;
         rx_cnt_q       <= rx_cnt_d;
         rx_bit_q       <= rx_bit_d;
         rx_shift_q     <= rx_shift_d;
         rx_hold_q      <= rx_hold_d;
         dataready_q    <= dataready_d;
`ifdef UART_PARITY_EN
         tx_par_q       <= tx_par_d;
         rx_par_err_q   <= rx_par_err_d;
`endif
      end
   end

endmodule

// File: doc/uart_bus_responder.md
UART_BUS_RESPONDER -- requirements
Module: uart_bus_responder

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 4..65535.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 data  inout  8  bus data; driven only while uart_rdn is low, otherwise high-Z.
REQ-005 uart_rdn  input  1  active-low read strobe from the bus master.
REQ-006 uart_wrn  input  1  active-low write strobe from the bus master.
REQ-007 uart_dataready  output  1  high = received byte waiting.
REQ-008 uart_tbre  output  1  high = transmit holding register empty.
REQ-009 uart_tsre  output  1  high = transmit shifter idle and holding register empty.
REQ-010 txd  output  1  serial transmit line, idles high.
REQ-011 rxd  input  1  serial receive line, asynchronous to clk.

Function
REQ-012 Strobes SHALL be registered each cycle; a falling edge is a registered value of 1 with a current value of 0, and a rising edge is the reverse.
REQ-013 On a uart_wrn falling edge with tbre=1, data[7:0] SHALL be latched into the holding register and tbre SHALL be 0 from that same clock edge.
REQ-014 A uart_wrn falling edge with tbre=0 SHALL be ignored; the holding register and the transmission in progress are unchanged.
REQ-015 TX FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 In IDLE with the holding register full, the next edge SHALL load the shifter, set tbre=1, tsre=0, enter START, and drive txd=0.
REQ-017 Each TX state SHALL last exactly CLKS_PER_BIT cycles; DATA sends 8 bits LSB first; STOP drives txd=1.
REQ-018 At the end of STOP, the FSM SHALL go to IDLE; tsre=1 only if the holding register is empty, otherwise back-to-back load per REQ-016 with no extra idle bit.
REQ-019 rxd SHALL pass through a 2-flop synchronizer before use.
REQ-020 RX FSM states: IDLE, START, DATA, PARITY (macro only), STOP; a synchronized high-to-low transition in IDLE enters START.
REQ-021 START SHALL resample at CLKS_PER_BIT/2 (integer division); if rxd=1 there, the FSM SHALL return to IDLE (glitch rejection).
REQ-022 Data and stop bits SHALL be sampled every CLKS_PER_BIT cycles after the mid-start sample, LSB first.
REQ-023 A stop sample of 1 SHALL write the byte to the RX holding register and set dataready=1 on the next edge; a stop sample of 0 SHALL discard the frame and leave dataready and the holding register unchanged.
REQ-024 While uart_rdn=0, data SHALL drive the RX holding register combinationally; there is no state change while the strobe is held.
REQ-025 A uart_rdn rising edge SHALL clear dataready.
REQ-026 A frame completing while dataready=1 SHALL overwrite the holding register (overrun; latest byte wins).
REQ-027 A rising edge of uart_rdn in the same cycle as a frame completion SHALL leave dataready=1 with the new byte.
REQ-028 Simultaneous uart_rdn=0 and uart_wrn=0 SHALL be handled independently; the bus drive follows REQ-024.

Reset
REQ-029 While rst_n=0: txd=1, tbre=1, tsre=1, dataready=0, data high-Z, both FSMs in IDLE, counters and registers 0.
REQ-030 Reset asserted mid-frame SHALL abort both directions immediately, with txd=1 asynchronously; no partial byte is retained.

Configuration
REQ-031 Macro UART_PARITY_EN: when defined, TX SHALL insert an even-parity bit between DATA and STOP, and RX SHALL sample it and discard frames with bad parity, as in REQ-023.
REQ-032 Without UART_PARITY_EN, there are no parity states and frames are 8N1.

Verification (CLKS_PER_BIT=4)
REQ-033 Write 0xA5 via uart_wrn -> tbre=0 for one cycle; txd = 0, then 1,0,1,0,0,1,0,1, then 1, each bit for 4 cycles; tsre=1 after stop.
REQ-034 Two writes of 0x55 then 0x0F, with the second issued while tbre=1 mid-frame -> two contiguous frames; a third write while tbre=0 is dropped.
REQ-035 Drive the 0x3C frame on rxd -> dataready=1; pulse uart_rdn -> data=0x3C while low, then dataready=0 after the rising edge.
REQ-036 2-cycle low glitch on rxd -> no frame, dataready stays 0; a frame with stop=0 -> discarded.
REQ-037 Receive 0x11 then 0x22 with no read in between -> read returns 0x22; rst_n pulsed mid-TX -> txd=1 immediately, tbre=tsre=1.
REQ-038 With UART_PARITY_EN, write 0x07 -> parity bit 1; receive 0x07 with parity 0 -> discarded.
